stream_in_port: RTL and testbench

AXI4-Stream video slave that accepts a pixel stream framed by `axi_tuser` (start of frame) and `axi_tlast` (end of line), checks line and frame geometry against `hactive`/`vactive`, and writes accepted pixels into the VDMA write FIFO. Each written word carries frame, line and end-of-frame markers. It is the ingress counterpart of the stream output port and feeds the write-side burst logic.

---
 rtl/stream_in_port_pkg.sv | 15 +
 rtl/stream_in_port.sv | 179 +++++++++++++++++
 tb/tb_stream_in_port.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_in_port_pkg.sv
// Shared VDMA definitions: ingress FSM encoding, SOF resync options and geometry width.
package stream_in_port_pkg;

  localparam int GEOM_W = 16;

  localparam string SOF_RESYNC_ON  = "ON";
  localparam string SOF_RESYNC_OFF = "OFF";

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DROP     = 2'd2
  } state_e;

endpackage

// File: rtl/stream_in_port.sv
// AXI4-Stream video slave: frames pixels by tuser/tlast, checks geometry against
// hactive/vactive and writes accepted pixels with frame/line markers into the VDMA FIFO.
module stream_in_port
  import stream_in_port_pkg::*;
#(
  parameter int    DSIZE      = 24,
  parameter string SOF_RESYNC = "ON"
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [GEOM_W-1:0] vactive,
  input  logic [GEOM_W-1:0] hactive,
  input  logic [DSIZE-1:0]  axi_tdata,
  input  logic              axi_tvalid,
  output logic              axi_tready,
  input  logic              axi_tuser,
  input  logic              axi_tlast,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [DSIZE-1:0]  wr_data,
  output logic              falign,
  output logic              lalign,
  output logic              ealign,
  output logic              frame_done,
  output logic              err_short,
  output logic              err_long,
  output logic              err_sof
);

  localparam bit RESYNC_EN = (SOF_RESYNC == SOF_RESYNC_ON);

  state_e            state_q, state_d;
  logic [GEOM_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [GEOM_W-1:0] hact_q, hact_d, vact_q, vact_d;
  logic              frame_end_q, frame_end_d;
  logic              drop_first_q, drop_first_d;
  logic              wr_en_q, wr_en_d;
  logic [DSIZE-1:0]  wr_data_q, wr_data_d;
  logic              falign_q, falign_d, lalign_q, lalign_d, ealign_q, ealign_d;
  logic              frame_done_q, frame_done_d;
  logic              err_short_q, err_short_d, err_long_q, err_long_d, err_sof_q, err_sof_d;

  logic              accept, sof_start, do_pixel, over;
  logic [GEOM_W-1:0] geo_h, geo_v, h_base, v_base, n;

  assign axi_tready = (state_q == ACTIVE) ? ~fifo_full : 1'b1;
  assign accept     = axi_tvalid & axi_tready;
  assign sof_start  = accept & axi_tuser & ((state_q == WAIT_SOF) | RESYNC_EN);

  // A start of frame is treated as pixel 0 of line 0 using the freshly sampled geometry,
  // so single-pixel lines/frames fall out of the common end-of-line path.
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    hact_d       = hact_q;
    vact_d       = vact_q;
    frame_end_d  = frame_end_q;
    drop_first_d = drop_first_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    falign_d     = 1'b0;
    lalign_d     = 1'b0;
    ealign_d     = 1'b0;
    frame_done_d = 1'b0;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;
    err_sof_d    = 1'b0;
    geo_h        = hact_q;
    geo_v        = vact_q;
    h_base       = hcnt_q;
    v_base       = vcnt_q;
    do_pixel     = 1'b0;
    over         = 1'b0;

    if (sof_start) begin
      geo_h     = hactive;
      geo_v     = vactive;
      h_base    = '0;
      v_base    = '0;
      hact_d    = hactive;
      vact_d    = vactive;
      err_sof_d = (state_q != WAIT_SOF);
      do_pixel  = (hactive != '0) && (vactive != '0);
      if (!do_pixel) begin
        state_d = WAIT_SOF;
        hcnt_d  = '0;
        vcnt_d  = '0;
      end
    end else if (accept && state_q == ACTIVE) begin
      do_pixel = 1'b1;
    end else if (accept && state_q == DROP) begin
      err_long_d   = drop_first_q;
      drop_first_d = 1'b0;
      if (axi_tlast) begin
        state_d = frame_end_q ? WAIT_SOF : ACTIVE;
      end
    end

    n = h_base + 16'd1;

    if (do_pixel) begin
      wr_en_d   = 1'b1;
      wr_data_d = axi_tdata;
      falign_d  = sof_start;
      if (axi_tlast || n == geo_h) begin
        lalign_d     = 1'b1;
        err_short_d  = axi_tlast && (n != geo_h);
        over         = !axi_tlast && !sof_start;
        hcnt_d       = '0;
        drop_first_d = 1'b1;
        if (v_base + 16'd1 == geo_v) begin
          ealign_d     = 1'b1;
          frame_done_d = 1'b1;
          frame_end_d  = 1'b1;
          vcnt_d       = '0;
          state_d      = over ? DROP : WAIT_SOF;
        end else begin
          frame_end_d  = 1'b0;
          vcnt_d       = v_base + 16'd1;
          state_d      = over ? DROP : ACTIVE;
        end
      end else begin
        hcnt_d  = n;
        vcnt_d  = v_base;
        state_d = ACTIVE;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_SOF;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      hact_q       <= '0;
      vact_q       <= '0;
      frame_end_q  <= 1'b0;
      drop_first_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      falign_q     <= 1'b0;
      lalign_q     <= 1'b0;
      ealign_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      hact_q       <= hact_d;
      vact_q       <= vact_d;
      frame_end_q  <= frame_end_d;
      drop_first_q <= drop_first_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      falign_q     <= falign_d;
      lalign_q     <= lalign_d;
      ealign_q     <= ealign_d;
      frame_done_q <= frame_done_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      err_sof_q    <= err_sof_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign falign     = falign_q;
  assign lalign     = lalign_q;
  assign ealign     = ealign_q;
  assign frame_done = frame_done_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign err_sof    = err_sof_q;

endmodule

// File: tb/tb_stream_in_port.sv
// Scoreboard bench for stream_in_port: stimulus pushes expected FIFO writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_stream_in_port;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] vactive = 16'd3;
  logic [15:0] hactive = 16'd4;
  logic [23:0] axi_tdata = '0;
  logic        axi_tvalid = 1'b0;
  logic        axi_tready;
  logic        axi_tuser = 1'b0;
  logic        axi_tlast = 1'b0;
  logic        fifo_full = 1'b0;
  logic        wr_en;
  logic [23:0] wr_data;
  logic        falign, lalign, ealign, frame_done;
  logic        err_short, err_long, err_sof;

  typedef struct packed {
    logic [23:0] data;
    logic        f;
    logic        l;
    logic        e;
  } exp_t;

  exp_t expQ[$];
  int   checksTotal = 0;
  int   checksPassed = 0;
  int   errShortCnt = 0;
  int   errLongCnt = 0;
  int   errSofCnt = 0;

  stream_in_port #(.DSIZE(24), .SOF_RESYNC("ON")) dut (
    .clock(clock), .rst(rst), .vactive(vactive), .hactive(hactive),
    .axi_tdata(axi_tdata), .axi_tvalid(axi_tvalid), .axi_tready(axi_tready),
    .axi_tuser(axi_tuser), .axi_tlast(axi_tlast), .fifo_full(fifo_full),
    .wr_en(wr_en), .wr_data(wr_data), .falign(falign), .lalign(lalign),
    .ealign(ealign), .frame_done(frame_done), .err_short(err_short),
    .err_long(err_long), .err_sof(err_sof)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Monitor: every FIFO write must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!rst) begin
      if (err_short) errShortCnt++;
      if (err_long)  errLongCnt++;
      if (err_sof)   errSofCnt++;
      if (wr_en) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_wr", {31'd0, wr_en}, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("wr_data",    {8'd0, wr_data}, {8'd0, e.data});
          checkOutput("falign",     {31'd0, falign}, {31'd0, e.f});
          checkOutput("lalign",     {31'd0, lalign}, {31'd0, e.l});
          checkOutput("ealign",     {31'd0, ealign}, {31'd0, e.e});
          checkOutput("frame_done", {31'd0, frame_done}, {31'd0, e.e});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [23:0] d, input bit u, input bit l, input bit expW,
                               input bit ef, input bit el, input bit ee, output int stalls);
    bit done;
    done = 1'b0;
    stalls = 0;
    axi_tdata  = d;
    axi_tuser  = u;
    axi_tlast  = l;
    axi_tvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (axi_tready) begin
        if (expW) expQ.push_back('{data: d, f: ef, l: el, e: ee});
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clock);
      #1;
    end
    if (!done) checkOutput("accept_timeout", {31'd0, axi_tready}, 32'd1);
  endtask

  task automatic idle();
    axi_tvalid = 1'b0;
    axi_tuser  = 1'b0;
    axi_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    idle();
    while (expQ.size() != 0 && k < 20) begin
      @(posedge clock);
      k++;
    end
    repeat (2) @(posedge clock);
    #1;
    checkOutput(name, expQ.size(), 32'd0);
  endtask

  task automatic sendFrame(input logic [23:0] base);
    int st;
    for (int i = 0; i < 12; i++)
      applyStimulus(base + 24'(i), i == 0, (i % 4) == 3, 1'b1, i == 0, (i % 4) == 3, i == 11, st);
  endtask

  initial begin
    int st, s0, l0, f0, totalStall;

    #1;
    checkOutput("rst_tready", {31'd0, axi_tready}, 32'd1);
    checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("rst_wr_data", {8'd0, wr_data}, 32'd0);
    checkOutput("rst_markers", {28'd0, falign, lalign, ealign, frame_done}, 32'd0);
    checkOutput("rst_errs", {29'd0, err_short, err_long, err_sof}, 32'd0);
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    $display("[TB] clean frame");
    s0 = errShortCnt; l0 = errLongCnt; f0 = errSofCnt;
    sendFrame(24'h000100);
    drain("clean_drain");
    checkOutput("clean_errs", errShortCnt - s0 + errLongCnt - l0 + errSofCnt - f0, 32'd0);

    $display("[TB] pre-SOF garbage");
    totalStall = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(24'hBAD000 + 24'(i), 1'b0, i == 4, 1'b0, 1'b0, 1'b0, 1'b0, st);
      totalStall += st;
    end
    checkOutput("garbage_stalls", totalStall, 32'd0);
    sendFrame(24'h000200);
    drain("garbage_drain");

    $display("[TB] short line");
    s0 = errShortCnt;
    for (int i = 0; i < 4; i++)
      applyStimulus(24'h300 + 24'(i), i == 0, i == 3, 1'b1, i == 0, i == 3, 1'b0, st);
    applyStimulus(24'h310, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, st);
    applyStimulus(24'h311, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, st);
    for (int i = 0; i < 4; i++)
      applyStimulus(24'h320 + 24'(i), 1'b0, i == 3, 1'b1, 1'b0, i == 3, i == 3, st);
    drain("short_drain");
    checkOutput("err_short_cnt", errShortCnt - s0, 32'd1);

    $display("[TB] long line");
    l0 = errLongCnt;
    for (int i = 0; i < 6; i++)
      applyStimulus(24'h400 + 24'(i), i == 0, i == 5, i < 4, i == 0, i == 3, 1'b0, st);
    for (int i = 0; i < 8; i++)
      applyStimulus(24'h410 + 24'(i), 1'b0, (i % 4) == 3, 1'b1, 1'b0, (i % 4) == 3, i == 7, st);
    drain("long_drain");
    checkOutput("err_long_cnt", errLongCnt - l0, 32'd1);

    $display("[TB] fifo_full stall");
    totalStall = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        fork
          begin
            fifo_full = 1'b1;
            repeat (3) @(posedge clock);
            #1 fifo_full = 1'b0;
          end
        join_none
      end
      applyStimulus(24'h500 + 24'(i), i == 0, (i % 4) == 3, 1'b1, i == 0, (i % 4) == 3, i == 11, st);
      totalStall += st;
    end
    drain("stall_drain");
    checkOutput("stall_cycles", totalStall, 32'd3);

    $display("[TB] SOF resync");
    f0 = errSofCnt;
    for (int i = 0; i < 4; i++)
      applyStimulus(24'h600 + 24'(i), i == 0, i == 3, 1'b1, i == 0, i == 3, 1'b0, st);
    applyStimulus(24'h610, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, st);
    for (int i = 0; i < 12; i++)
      applyStimulus(24'h700 + 24'(i), i == 0, (i % 4) == 3, 1'b1, i == 0, (i % 4) == 3, i == 11, st);
    drain("resync_drain");
    checkOutput("err_sof_cnt", errSofCnt - f0, 32'd1);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 6; i++)
      applyStimulus(24'h800 + 24'(i), i == 0, (i % 4) == 3, 1'b1, i == 0, (i % 4) == 3, 1'b0, st);
    drain("partial_drain");
    rst = 1'b1;
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    #1;
    checkOutput("post_rst_tready", {31'd0, axi_tready}, 32'd1);
    checkOutput("post_rst_wr_en", {31'd0, wr_en}, 32'd0);
    applyStimulus(24'h8FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, st);
    sendFrame(24'h000900);
    drain("post_rst_drain");

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
